// File: rtl/pipe_pkg.sv
// Shared types for the pipeline hazard/forwarding controller.
package pipe_pkg;

    // Default register-index width; the controller can override it.
    localparam int unsigned REG_AW_DEF = 5;

    // EXE operand source selects.
    typedef enum logic [1:0] {
        FWD_REG = 2'd0,
        FWD_MEM = 2'd1,
        FWD_WB  = 2'd2
    } fwd_sel_e;

    // Shadow-slot control flags. The destination index stays outside the
    // struct because its width follows the controller's REG_AW parameter.
    typedef struct packed {
        logic valid;
        logic wb_en;
        logic mem_read;
    } slot_ctl_t;

endpackage

// File: rtl/hz_slot_match.sv
// Compares one shadow slot's destination against one source index.
module hz_slot_match
    import pipe_pkg::*;
#(
    parameter int unsigned REG_AW       = REG_AW_DEF,
    parameter int unsigned R0_HARDWIRED = 1
) (
    input  logic              slot_valid,
    input  logic              slot_wb_en,
    input  logic [REG_AW-1:0] slot_dest,
    input  logic [REG_AW-1:0] src,
    output logic              hit
);

    // A live register writer targeting src; r0 never matches when hardwired.
    always_comb begin
        hit = slot_valid && slot_wb_en && (src == slot_dest);
        if ((R0_HARDWIRED != 0) && (src == '0)) begin
            hit = 1'b0;
        end
    end

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// Hazard detection, load-latency freeze, branch flush and EXE forwarding
// selects for the 5-stage pipeline, driven from a shadow copy of EX/MEM/WB.
module pipeline_hazard_ctrl
    import pipe_pkg::*;
#(
    parameter int unsigned REG_AW       = REG_AW_DEF,
    parameter int unsigned MEM_LATENCY  = 1,
    parameter int unsigned R0_HARDWIRED = 1,
    parameter int unsigned STAT_W       = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              fwd_en,
    input  logic              id_valid,
    input  logic [REG_AW-1:0] id_src1,
    input  logic [REG_AW-1:0] id_src2,
    input  logic              id_uses_src2,
    input  logic              id_wb_en,
    input  logic              id_mem_read,
    input  logic [REG_AW-1:0] id_dest,
    input  logic              br_taken,
    output logic              id_stall,
    output logic              pipe_stall,
    output logic              flush,
    output logic [1:0]        fwd_a_sel,
    output logic [1:0]        fwd_b_sel,
    output logic [STAT_W-1:0] stall_cnt
);

    localparam int unsigned WAIT_W = (MEM_LATENCY > 1) ? $clog2(MEM_LATENCY) : 1;
    localparam logic [WAIT_W-1:0] LOAD_VAL = WAIT_W'(MEM_LATENCY - 1);

    slot_ctl_t         ex_ctl_q, ex_ctl_d, mem_ctl_q, mem_ctl_d, wb_ctl_q, wb_ctl_d;
    logic [REG_AW-1:0] ex_dest_q, ex_dest_d, mem_dest_q, mem_dest_d, wb_dest_q, wb_dest_d;
    logic [REG_AW-1:0] ex_src1_q, ex_src1_d, ex_src2_q, ex_src2_d;
    logic              ex_uses_src2_q, ex_uses_src2_d;
    logic [WAIT_W-1:0] wait_q, wait_d;
    logic [STAT_W-1:0] stall_cnt_q, stall_cnt_d;

    logic id_ex_hit1, id_ex_hit2, id_mem_hit1, id_mem_hit2;
    logic ex_mem_hit1, ex_mem_hit2, ex_wb_hit1, ex_wb_hit2;
    logic hazard_w, id_stall_w, pipe_stall_w, flush_w;
    fwd_sel_e fwd_a_w, fwd_b_w;

    // ID sources against the EX and MEM slots (stall detection).
    hz_slot_match #(.REG_AW(REG_AW), .R0_HARDWIRED(R0_HARDWIRED)) u_id_ex1 (
        .slot_valid(ex_ctl_q.valid), .slot_wb_en(ex_ctl_q.wb_en),
        .slot_dest(ex_dest_q), .src(id_src1), .hit(id_ex_hit1));
    hz_slot_match #(.REG_AW(REG_AW), .R0_HARDWIRED(R0_HARDWIRED)) u_id_ex2 (
        .slot_valid(ex_ctl_q.valid), .slot_wb_en(ex_ctl_q.wb_en),
        .slot_dest(ex_dest_q), .src(id_src2), .hit(id_ex_hit2));
    hz_slot_match #(.REG_AW(REG_AW), .R0_HARDWIRED(R0_HARDWIRED)) u_id_mem1 (
        .slot_valid(mem_ctl_q.valid), .slot_wb_en(mem_ctl_q.wb_en),
        .slot_dest(mem_dest_q), .src(id_src1), .hit(id_mem_hit1));
    hz_slot_match #(.REG_AW(REG_AW), .R0_HARDWIRED(R0_HARDWIRED)) u_id_mem2 (
        .slot_valid(mem_ctl_q.valid), .slot_wb_en(mem_ctl_q.wb_en),
        .slot_dest(mem_dest_q), .src(id_src2), .hit(id_mem_hit2));

    // EX sources against the MEM and WB slots (forwarding).
    hz_slot_match #(.REG_AW(REG_AW), .R0_HARDWIRED(R0_HARDWIRED)) u_ex_mem1 (
        .slot_valid(mem_ctl_q.valid), .slot_wb_en(mem_ctl_q.wb_en),
        .slot_dest(mem_dest_q), .src(ex_src1_q), .hit(ex_mem_hit1));
    hz_slot_match #(.REG_AW(REG_AW), .R0_HARDWIRED(R0_HARDWIRED)) u_ex_mem2 (
        .slot_valid(mem_ctl_q.valid), .slot_wb_en(mem_ctl_q.wb_en),
        .slot_dest(mem_dest_q), .src(ex_src2_q), .hit(ex_mem_hit2));
    hz_slot_match #(.REG_AW(REG_AW), .R0_HARDWIRED(R0_HARDWIRED)) u_ex_wb1 (
        .slot_valid(wb_ctl_q.valid), .slot_wb_en(wb_ctl_q.wb_en),
        .slot_dest(wb_dest_q), .src(ex_src1_q), .hit(ex_wb_hit1));
    hz_slot_match #(.REG_AW(REG_AW), .R0_HARDWIRED(R0_HARDWIRED)) u_ex_wb2 (
        .slot_valid(wb_ctl_q.valid), .slot_wb_en(wb_ctl_q.wb_en),
        .slot_dest(wb_dest_q), .src(ex_src2_q), .hit(ex_wb_hit2));

    // Stall, freeze and flush decisions for the current cycle.
    always_comb begin
        logic dep_ex, dep_mem;
        dep_ex  = id_ex_hit1  || (id_uses_src2 && id_ex_hit2);
        dep_mem = id_mem_hit1 || (id_uses_src2 && id_mem_hit2);
        if (fwd_en) begin
            hazard_w = id_valid && ex_ctl_q.mem_read && dep_ex;
        end else begin
            hazard_w = id_valid && (dep_ex || dep_mem);
        end
        pipe_stall_w = (wait_q != '0);
        // A taken branch kills the ID instruction, so its hazard is moot.
        id_stall_w   = hazard_w && !br_taken && !pipe_stall_w;
        // A frozen branch is re-presented and flushes once the freeze lifts.
        flush_w      = br_taken && !pipe_stall_w && !rst;
    end

    // Operand forwarding selects; MEM beats WB, a load in MEM cannot forward.
    always_comb begin
        fwd_a_w = FWD_REG;
        fwd_b_w = FWD_REG;
        if (fwd_en) begin
            if (ex_mem_hit1 && !mem_ctl_q.mem_read) begin
                fwd_a_w = FWD_MEM;
            end else if (ex_wb_hit1) begin
                fwd_a_w = FWD_WB;
            end
            if (ex_uses_src2_q) begin
                if (ex_mem_hit2 && !mem_ctl_q.mem_read) begin
                    fwd_b_w = FWD_MEM;
                end else if (ex_wb_hit2) begin
                    fwd_b_w = FWD_WB;
                end
            end
        end
    end

    // Shadow-slot advance, load wait counter and stall statistics.
    always_comb begin
        ex_ctl_d       = ex_ctl_q;
        ex_dest_d      = ex_dest_q;
        ex_src1_d      = ex_src1_q;
        ex_src2_d      = ex_src2_q;
        ex_uses_src2_d = ex_uses_src2_q;
        mem_ctl_d      = mem_ctl_q;
        mem_dest_d     = mem_dest_q;
        wb_ctl_d       = wb_ctl_q;
        wb_dest_d      = wb_dest_q;
        wait_d         = wait_q;
        stall_cnt_d    = stall_cnt_q;

        if (pipe_stall_w) begin
            wait_d = wait_q - WAIT_W'(1);
        end else begin
            wb_ctl_d   = mem_ctl_q;
            wb_dest_d  = mem_dest_q;
            mem_ctl_d  = ex_ctl_q;
            mem_dest_d = ex_dest_q;
            if (ex_ctl_q.valid && ex_ctl_q.mem_read) begin
                wait_d = LOAD_VAL;
            end
            if (id_stall_w || flush_w || !id_valid) begin
                ex_ctl_d       = '0;
                ex_dest_d      = '0;
                ex_src1_d      = '0;
                ex_src2_d      = '0;
                ex_uses_src2_d = 1'b0;
            end else begin
                ex_ctl_d       = '{valid: 1'b1, wb_en: id_wb_en, mem_read: id_mem_read};
                ex_dest_d      = id_dest;
                ex_src1_d      = id_src1;
                ex_src2_d      = id_src2;
                ex_uses_src2_d = id_uses_src2;
            end
        end

        if ((id_stall_w || pipe_stall_w) && (stall_cnt_q != '1)) begin
            stall_cnt_d = stall_cnt_q + STAT_W'(1);
        end
    end

    // State registers, cleared asynchronously.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ex_ctl_q       <= '0;
            ex_dest_q      <= '0;
            ex_src1_q      <= '0;
            ex_src2_q      <= '0;
            ex_uses_src2_q <= 1'b0;
            mem_ctl_q      <= '0;
            mem_dest_q     <= '0;
            wb_ctl_q       <= '0;
            wb_dest_q      <= '0;
            wait_q         <= '0;
            stall_cnt_q    <= '0;
        end else begin
            ex_ctl_q       <= ex_ctl_d;
            ex_dest_q      <= ex_dest_d;
            ex_src1_q      <= ex_src1_d;
            ex_src2_q      <= ex_src2_d;
            ex_uses_src2_q <= ex_uses_src2_d;
            mem_ctl_q      <= mem_ctl_d;
            mem_dest_q     <= mem_dest_d;
            wb_ctl_q       <= wb_ctl_d;
            wb_dest_q      <= wb_dest_d;
            wait_q         <= wait_d;
            stall_cnt_q    <= stall_cnt_d;
        end
    end

    assign id_stall   = id_stall_w;
    assign pipe_stall = pipe_stall_w;
    assign flush      = flush_w;
    assign fwd_a_sel  = fwd_a_w;
    assign fwd_b_sel  = fwd_b_w;
    assign stall_cnt  = stall_cnt_q;

endmodule

// File: doc/pipeline_hazard_ctrl.md
Name: pipeline_hazard_ctrl

Overview:
- Parametrised hazard, forwarding and stall controller for the 5-stage pipeline (IF, ID, EXE, MEM, WB). It supersedes the fixed hazard detector that has forwarding hard-tied on.
- Keeps its own shadow copy of the EXE/MEM/WB destination state.
- Generates the following, in one block:
  - ID-stage stall
  - full-pipe freeze for multi-cycle data memory
  - branch flush
  - EXE operand forwarding selects
- Forwarding can be switched on or off at run time.

Parameters:
REG_AW, 5, register-index width
MEM_LATENCY, 1, data-memory load latency in cycles (>=1); 1 means no extra freeze
R0_HARDWIRED, 1, when 1 a source/dest index of 0 never produces a hazard or forward
STAT_W, 16, stall-cycle counter width

Ports:
clk  in  1  clock
rst  in  1  asynchronous reset, active-high
fwd_en  in  1  1 = forwarding mode, 0 = stall-until-written mode
id_valid  in  1  ID holds a real instruction
id_src1  in  REG_AW  ID source 1
id_src2  in  REG_AW  ID source 2
id_uses_src2  in  1  ID instruction reads src2 as a register
id_wb_en  in  1  ID instruction writes the register file
id_mem_read  in  1  ID instruction is a load
id_dest  in  REG_AW  ID destination
br_taken  in  1  branch resolved taken in EXE
id_stall  out  1  hold PC and IF/ID register; insert bubble into EXE
pipe_stall  out  1  freeze every pipeline register (memory wait)
flush  out  1  kill IF/ID contents
fwd_a_sel  out  2  EXE operand A: 0 regfile, 1 MEM-stage ALU result, 2 WB data
fwd_b_sel  out  2  EXE operand B: same encoding
stall_cnt  out  STAT_W  saturating count of cycles with id_stall|pipe_stall

Behaviour:
- Shadow slots EX, MEM, WB. Each slot holds {valid, wb_en, mem_read, dest}; EX also holds {src1, src2, uses_src2}.
- On reset: all slots invalid, wait counter 0, stall_cnt 0. Every output is 0 while rst is high and on the first cycle after reset.
- match(s, d) = valid slot with wb_en, d == slot dest, and NOT (R0_HARDWIRED and d == 0). src2 participates only when uses_src2 = 1.
- Hazard (combinational from ID inputs and slots):
  - fwd_en = 1: hazard = id_valid and EX.mem_read and match(EX, src).
  - fwd_en = 0: hazard = id_valid and (match(EX, src) or match(MEM, src)).
  - WB is never a hazard; the register file is write-before-read.
- Load wait counter:
  - When a load advances from EX into MEM, the counter loads MEM_LATENCY-1.
  - pipe_stall = (counter != 0). While pipe_stall: counter decrements; all slots hold.
- id_stall = hazard and not br_taken and not pipe_stall. A taken branch kills the ID instruction, so its hazard is moot.
- flush = br_taken and not pipe_stall. The frozen branch is re-presented and flushes once when the freeze releases.
- Slot update, per clock, when not pipe_stall:
  - WB <= MEM and MEM <= EX.
  - EX <= bubble if id_stall or flush or not id_valid; otherwise EX <= the ID inputs.
- Forward select for EX src (per operand):
  - 1 if fwd_en and match(MEM, src) and not MEM.mem_read;
  - else 2 if fwd_en and match(WB, src);
  - else 0.
  - MEM has priority over WB.
  - Operand B select is 0 when EX.uses_src2 = 0.
  - All selects are 0 when fwd_en = 0.
- fwd_en changes take effect combinationally the same cycle; no slot state is cleared.
- stall_cnt increments on any cycle with id_stall or pipe_stall and saturates at all-ones.
- Reset mid-operation (including mid-freeze) clears everything immediately.

Decomposition:
- Shared package pipe_pkg holds:
  - fwd-select encodings FWD_REG=0, FWD_MEM=1, FWD_WB=2
  - the shadow-slot struct
  - REG_AW default
- One natural sub-module, hz_slot_match: compares a slot against one source index, with the R0 and valid/wb_en qualification. It is instantiated per slot/source pair.

Test Plan:
- RAW with fwd_en=1: ADD r3 followed immediately by SUB using r3 -> no id_stall; fwd_a_sel=1 on SUB's EXE cycle. With one unrelated instruction between them -> fwd_a_sel=2.
- Load-use: LD r4 followed by ADD using r4, fwd_en=1, MEM_LATENCY=1 -> id_stall=1 for exactly 1 cycle; then fwd_a_sel=2; stall_cnt=1.
- fwd_en=0: ADD r5 followed by use of r5 -> id_stall for 2 cycles; fwd selects stay 0 throughout.
- MEM_LATENCY=3: a load enters MEM -> pipe_stall high for exactly 2 cycles with slots frozen. br_taken asserted during the freeze -> flush=0 during the freeze, then flush=1 on the first unfrozen cycle.
- Branch plus hazard in the same cycle: load in EXE, dependent instruction in ID, br_taken=1 -> id_stall=0, flush=1; EX receives a bubble.
- R0 and reset: write to r0 followed by a read of r0 -> no stall and selects 0. Assert rst in the middle of a 3-cycle freeze -> pipe_stall, id_stall and stall_cnt all 0 immediately.
